// File: rtl/sampstream_arbiter.sv
// Round-robin arbiter that merges NUM_SRC sample-queue byte streams into one
// host-bound stream, framing each grant as a 2-byte header plus snapshot payload.
module sampstream_arbiter #(
    parameter int         NUM_SRC = 4,
    parameter logic [3:0] HDR_TAG = 4'd5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8*NUM_SRC-1:0]  src_data,
    input  logic [10*NUM_SRC-1:0] src_count,
    input  logic [NUM_SRC-1:0]    src_avail,
    output logic [NUM_SRC-1:0]    src_pull,
    input  logic [NUM_SRC-1:0]    src_enable,
    output logic [7:0]            out_data,
    output logic                  out_avail,
    input  logic                  out_pull,
    output logic                  busy,
    output logic [2:0]            cur_src
);

    localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR0 = 2'd1,
        HDR1 = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t          state;
    logic [RW-1:0]   cur_idx;
    logic [RW-1:0]   rr_last;
    logic [9:0]      remaining;
    logic            busy_q;

    logic [7:0]         data_arr  [NUM_SRC];
    logic [9:0]         count_arr [NUM_SRC];
    logic [NUM_SRC-1:0] elig;
    logic               grant_found;
    logic [RW-1:0]      grant_idx;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign data_arr[g]  = src_data[8*g +: 8];
        assign count_arr[g] = src_count[10*g +: 10];
        assign elig[g]      = src_avail[g] && src_enable[g] && (count_arr[g] != 10'd0);
    end

    // Scan starts just after the last winner so every source gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!grant_found && elig[(int'(rr_last) + k) % NUM_SRC]) begin
                grant_found = 1'b1;
                grant_idx   = RW'((int'(rr_last) + k) % NUM_SRC);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_idx   <= '0;
            rr_last   <= RW'(NUM_SRC - 1);
            remaining <= 10'd0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        cur_idx   <= grant_idx;
                        remaining <= count_arr[grant_idx];
                        busy_q    <= 1'b1;
                        state     <= HDR0;
                    end
                end
                HDR0: if (out_pull) state <= HDR1;
                HDR1: if (out_pull) state <= DATA;
                DATA: begin
                    if (out_pull) begin
                        remaining <= remaining - 10'd1;
                        if (remaining == 10'd1) begin
                            rr_last <= cur_idx;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake: a byte transfers in a cycle where out_avail && out_pull; in
    // DATA that same cycle consumes one byte from the granted source.
    assign out_avail = busy_q;
    assign busy      = busy_q;
    assign cur_src   = 3'(cur_idx);

    always_comb begin
        out_data = 8'h00;
        case (state)
            HDR0:    out_data = {HDR_TAG, 1'b0, cur_src};
            HDR1:    out_data = remaining[9:2];
            DATA:    out_data = data_arr[cur_idx];
            default: out_data = 8'h00;
        endcase
    end

    always_comb begin
        src_pull = '0;
        if (state == DATA) src_pull[cur_idx] = out_pull;
    end

endmodule

// File: tb/tb_sampstream_arbiter.sv
// Bench for sampstream_arbiter: counter-based source model, expected-byte queue
// filled at grant setup and drained by the output monitor.
module tb_sampstream_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [8*N-1:0] src_data;
    logic [10*N-1:0] src_count;
    logic [N-1:0]   src_avail;
    logic [N-1:0]   src_pull;
    logic [N-1:0]   src_enable;
    logic [7:0]     out_data;
    logic           out_avail;
    logic           out_pull = 1'b0;
    logic           busy;
    logic [2:0]     cur_src;

    logic [15:0]    ptr [N] = '{default: 16'd0};
    logic [7:0]     exp_q[$];
    logic [7:0]     mon_e;
    logic [N-1:0]   mon_onehot;
    int             pull_pct = 100;
    int             exp_src_now = -1;
    int             checks = 0;
    int             errors = 0;

    typedef struct {
        logic [N-1:0] avail;
        logic [N-1:0] en;
        int           cnt;
        int           new_cnt;
        int           pct;
        int           exp_src;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    sampstream_arbiter #(.NUM_SRC(N), .HDR_TAG(4'd5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_data   (src_data),
        .src_count  (src_count),
        .src_avail  (src_avail),
        .src_pull   (src_pull),
        .src_enable (src_enable),
        .out_data   (out_data),
        .out_avail  (out_avail),
        .out_pull   (out_pull),
        .busy       (busy),
        .cur_src    (cur_src)
    );

    // Source model: source s presents byte 0x10 + 0x40*s + (bytes consumed so far).
    for (genvar i = 0; i < N; i++) begin : g_src
        assign src_data[8*i +: 8] = 8'(32'h10 + 32'(i) * 32'h40 + 32'(ptr[i]));
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (src_pull[i]) ptr[i] <= ptr[i] + 16'd1;
    end

    function automatic logic [7:0] src_byte(int s, int k);
        return 8'(32'h10 + s * 32'h40 + 32'(ptr[s]) + k);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_counts(int c);
        for (int i = 0; i < N; i++) src_count[10*i +: 10] = 10'(c);
    endtask

    task automatic push_frame(int s, int cnt, int off);
        exp_q.push_back({4'h5, 1'b0, 3'(s)});
        exp_q.push_back(8'(cnt >> 2));
        for (int k = 0; k < cnt; k++) exp_q.push_back(src_byte(s, off + k));
    endtask

    // Output monitor and out_pull driver: drive at negedge, sample 1 ns later.
    initial begin
        forever begin
            @(negedge clk);
            out_pull = ($urandom_range(0, 99) < pull_pct);
            #1;
            if (out_avail && out_pull) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", out_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_byte", {24'd0, out_data}, {24'd0, mon_e});
                end
            end
            if (src_pull != '0) begin
                if (exp_src_now == -2) begin
                    check("src_pull_qual", {30'd0, out_pull, $onehot(src_pull)}, 32'd3);
                end else begin
                    mon_onehot = '0;
                    if (exp_src_now >= 0 && out_pull) mon_onehot[exp_src_now] = 1'b1;
                    check("src_pull", {28'd0, src_pull}, {28'd0, mon_onehot});
                end
            end
        end
    end

    task automatic run_grant(vec_t v, int idx);
        int start;
        logic seen;
        @(negedge clk);
        pull_pct    = v.pct;
        src_enable  = v.en;
        set_counts(v.cnt);
        src_avail   = v.avail;
        exp_src_now = v.exp_src;
        if (v.exp_src < 0) begin
            seen = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk); #2;
                if (busy || out_avail) seen = 1'b1;
            end
            check($sformatf("no_grant[%0d]", idx), {31'd0, seen}, 32'd0);
            src_avail = '0;
            return;
        end
        start = int'(ptr[v.exp_src]);
        push_frame(v.exp_src, v.cnt, 0);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk); #2;
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        check($sformatf("grant_start[%0d]", idx), {31'd0, seen}, 32'd1);
        src_avail = '0;
        set_counts(v.new_cnt);
        for (int n = 0; n < v.cnt * 20 + 50 && (exp_q.size() != 0 || busy); n++) begin
            @(negedge clk); #2;
        end
        check($sformatf("frame_done[%0d]", idx), {31'd0, busy}, 32'd0);
        check($sformatf("queue_empty[%0d]", idx), 32'(exp_q.size()), 32'd0);
        check($sformatf("cur_src[%0d]", idx), {29'd0, cur_src}, 32'(v.exp_src));
        check($sformatf("pulls[%0d]", idx), 32'(16'(ptr[v.exp_src] - 16'(start))), 32'(v.cnt));
        exp_q.delete();
    endtask

    initial begin
        int off [N];
        vecs[0]  = '{4'b0001, 4'b1111, 8,    8,    100,  0};
        vecs[1]  = '{4'b1111, 4'b1111, 4,    4,    100,  1};
        vecs[2]  = '{4'b1111, 4'b1111, 4,    4,    100,  2};
        vecs[3]  = '{4'b1111, 4'b1111, 4,    4,    100,  3};
        vecs[4]  = '{4'b1111, 4'b1111, 4,    4,    100,  0};
        vecs[5]  = '{4'b0110, 4'b1011, 4,    4,    100,  1};
        vecs[6]  = '{4'b0110, 4'b1011, 4,    4,    100,  1};
        vecs[7]  = '{4'b1001, 4'b1111, 8,    8,    100,  3};
        vecs[8]  = '{4'b1001, 4'b1111, 4,    4,    100,  0};
        vecs[9]  = '{4'b1000, 4'b1111, 12,   12,   100,  3};
        vecs[10] = '{4'b0100, 4'b1111, 12,   4,    100,  2};
        vecs[11] = '{4'b1111, 4'b1111, 0,    0,    100, -1};
        vecs[12] = '{4'b0010, 4'b1111, 1020, 1020, 30,   1};
        vecs[13] = '{4'b1100, 4'b0111, 4,    4,    100,  2};

        src_avail  = '0;
        src_enable = '1;
        set_counts(0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_avail", {31'd0, out_avail}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cur_src", {29'd0, cur_src}, 32'd0);
        check("rst_src_pull", {28'd0, src_pull}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_grant(vecs[i], i);

        // Reset in the middle of a payload aborts the frame at once.
        @(negedge clk);
        pull_pct    = 100;
        src_enable  = '1;
        set_counts(16);
        src_avail   = 4'b0001;
        exp_src_now = 0;
        push_frame(0, 16, 0);
        for (int n = 0; n < 40 && exp_q.size() > 11; n++) begin
            @(negedge clk); #2;
        end
        check("midframe_progress", 32'(exp_q.size()), 32'd11);
        rst_n = 1'b0;
        src_avail = '0;
        #1;
        check("abort_out_avail", {31'd0, out_avail}, 32'd0);
        check("abort_src_pull", {28'd0, src_pull}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All sources ready back-to-back after reset: order 0,1,2,3,0.
        @(negedge clk);
        set_counts(4);
        exp_src_now = -2;
        off = '{default: 0};
        for (int g = 0; g < 5; g++) begin
            push_frame(g % N, 4, off[g % N]);
            off[g % N] += 4;
        end
        src_avail = '1;
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
            @(negedge clk); #2;
        end
        src_avail = '0;
        check("rr_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        #2;
        check("rr_idle", {31'd0, busy}, 32'd0);
        check("rr_cur_src", {29'd0, cur_src}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
